// File: rtl/ipf_gen.sv
// ipf_gen: in-loop pixel filter (OFF / band offset / edge offset) for one colour plane of raster-ordered LCUs
//   in : clk, reset (async, active-low), in_en/din pixel stream, ipf_type/ipf_band_pos/ipf_wo_class/ipf_offset,
//        lcu_x/lcu_y/lcu_size sideband (captured on the first pixel of each LCU)
//   out: busy (upstream must stall), out_en/dout/dout_addr filtered pixel with absolute frame address,
//        finish (sticky, whole frame emitted)
module ipf_gen #(
  parameter int PIX_W = 8,
  parameter int OFF_W = 4,
  parameter int IMG_W = 128,
  parameter int LCU_MAX = 64,
  localparam int AW = 2 * $clog2(IMG_W),
  localparam int XW = $clog2(IMG_W / 16)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_en,
  input  logic [PIX_W-1:0]   din,
  input  logic [1:0]         ipf_type,
  input  logic [4:0]         ipf_band_pos,
  input  logic [1:0]         ipf_wo_class,
  input  logic [4*OFF_W-1:0] ipf_offset,
  input  logic [XW-1:0]      lcu_x,
  input  logic [XW-1:0]      lcu_y,
  input  logic [1:0]         lcu_size,
  output logic               busy,
  output logic               out_en,
  output logic [PIX_W-1:0]   dout,
  output logic [AW-1:0]      dout_addr,
  output logic               finish
);
  localparam int CW = $clog2(LCU_MAX);
  localparam int LW = $clog2(IMG_W);
  typedef enum logic [1:0] {READ, OUT, FINISH} state_t;
  state_t st;
  logic [PIX_W-1:0] lb [3][LCU_MAX];
  logic [CW-1:0] wrow, wcol, orow, ocol;
  logic [1:0] wslot, oslot;
  logic pair;
  logic [1:0] ty, cls, sz;
  logic [4:0] bp;
  logic [4*OFF_W-1:0] offs;
  logic [XW-1:0] lx, ly;
  logic [CW-1:0] s_last, cm, cp, a_col, b_col;
  logic [XW-1:0] l_last;
  logic [1:0] ps, ns, wnx, wpv, a_slot, b_slot, k;
  logic [PIX_W-1:0] c, a, b, fval;
  logic [4:0] band;
  logic [5:0] bd;
  logic po_hit, brd, wo_hit, hit, first;
  logic [1:0] k_wo;
  logic [OFF_W-1:0] o;
  logic [PIX_W:0] sum;
  logic [LW-1:0] ay, ax;
  assign s_last = CW'((16 << sz) - 1);
  assign l_last = XW'((IMG_W / 16 >> sz) - 1);
  assign first = wrow == '0 && wcol == '0;
  assign wnx = wslot == 2'd2 ? 2'd0 : wslot + 2'd1;
  assign wpv = wslot == 2'd0 ? 2'd2 : wslot - 2'd1;
  // rows live in a 3-slot ring: ps/ns are the slots of the rows above/below the one being emitted
  assign ps = oslot == 2'd0 ? 2'd2 : oslot - 2'd1;
  assign ns = oslot == 2'd2 ? 2'd0 : oslot + 2'd1;
  assign cm = ocol - 1'b1;
  assign cp = ocol + 1'b1;
  assign a_slot = cls == 2'd0 ? oslot : ps;
  assign b_slot = cls == 2'd0 ? oslot : ns;
  assign a_col = cls == 2'd1 ? ocol : cls == 2'd3 ? cp : cm;
  assign b_col = cls == 2'd1 ? ocol : cls == 2'd3 ? cm : cp;
  assign c = lb[oslot][ocol];
  assign a = lb[a_slot][a_col];
  assign b = lb[b_slot][b_col];
  always_comb begin
    brd = cls == 2'd0 ? (ocol == '0 || ocol == s_last) :
          cls == 2'd1 ? (orow == '0 || orow == s_last) :
          (ocol == '0 || ocol == s_last || orow == '0 || orow == s_last);
    band = c[PIX_W-1 -: 5];
    bd = {1'b0, band} - {1'b0, bp};
    po_hit = !bd[5] && bd[4:2] == 3'd0;
    // no category when both neighbours equal the centre or the centre lies strictly between them
    wo_hit = !brd && (c != a || c != b) && !((c < a && c > b) || (c > a && c < b));
    k_wo = (c < a && c < b) ? 2'd0 : (c < a || c < b) ? 2'd1 : (c > a && c > b) ? 2'd3 : 2'd2;
    hit = ty == 2'd1 ? po_hit : ty == 2'd2 ? wo_hit : 1'b0;
    k = ty == 2'd1 ? bd[1:0] : k_wo;
    o = OFF_W'(offs >> (OFF_W * (3 - int'(k))));
    sum = {1'b0, c} + {{(PIX_W + 1 - OFF_W){o[OFF_W-1]}}, o};
    // a carry/borrow out of the pixel range saturates toward the sign of the offset
    fval = !hit ? c : !sum[PIX_W] ? sum[PIX_W-1:0] : {PIX_W{~o[OFF_W-1]}};
    ay = (LW'(ly) << (3'd4 + 3'(sz))) + LW'(orow);
    ax = (LW'(lx) << (3'd4 + 3'(sz))) + LW'(ocol);
  end
  always_ff @(posedge clk)
    if (in_en && st == READ) lb[wslot][wcol] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= READ;
      {wrow, wcol, orow, ocol, wslot, oslot, pair} <= '0;
      {ty, cls, sz, bp, offs, lx, ly} <= '0;
      {busy, out_en, dout, dout_addr, finish} <= '0;
    end else case (st)
      READ: begin
        out_en <= 1'b0;
        if (in_en) begin
          if (first) {ty, bp, cls, offs, lx, ly, sz} <= {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size};
          wcol <= wcol == s_last ? '0 : wcol + 1'b1;
          if (wcol == s_last) begin
            wrow <= wrow + 1'b1;
            wslot <= wnx;
            if (wrow != '0) begin
              st <= OUT;
              busy <= 1'b1;
              orow <= wrow - 1'b1;
              ocol <= '0;
              oslot <= wpv;
              pair <= wrow == s_last;
            end
          end
        end
      end
      OUT: begin
        out_en <= 1'b1;
        dout <= fval;
        dout_addr <= {ay, ax};
        ocol <= ocol + 1'b1;
        if (ocol == s_last) begin
          ocol <= '0;
          orow <= orow + 1'b1;
          oslot <= ns;
          if (!pair || orow == s_last) begin
            busy <= 1'b0;
            st <= (orow == s_last && lx == l_last && ly == l_last) ? FINISH : READ;
            if (orow == s_last) {wrow, wcol, wslot} <= '0;
          end
        end
      end
      default: begin
        busy <= 1'b0;
        out_en <= 1'b0;
        finish <= 1'b1;
      end
    endcase
endmodule

// File: tb/tb_ipf_gen.sv
// tb_ipf_gen: randomized scoreboard bench for ipf_gen against a frame-level reference model
module tb_ipf_gen;
  logic clk = 1'b0, reset = 1'b0, in_en = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] ipf_type = '0, ipf_wo_class = '0, lcu_size = '0;
  logic [4:0] ipf_band_pos = '0;
  logic [15:0] ipf_offset = '0;
  logic [2:0] lcu_x = '0, lcu_y = '0;
  logic busy, out_en, finish;
  logic [7:0] dout;
  logic [13:0] dout_addr;
  typedef struct packed {logic [7:0] d; logic [13:0] a;} exp_t;
  exp_t exp_q[$];
  int img [64][64];
  int n_chk = 0, n_fail = 0, n_out = 0, cur_s = 16, run = 0;
  logic busy_prev = 1'b0, cap_first = 1'b0;
  logic [13:0] first_addr = '0;

  ipf_gen dut (
    .clk(clk), .reset(reset), .in_en(in_en), .din(din), .ipf_type(ipf_type),
    .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
    .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .busy(busy), .out_en(out_en),
    .dout(dout), .dout_addr(dout_addr), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_pix(int r, int c, int s, int ty, int bp, int cl, logic [15:0] off);
    int p, k, dr, dc, ra, ca, rb, cb, sg, v;
    p = img[r][c];
    k = -1;
    if (ty == 1 && (p >> 3) >= bp && (p >> 3) <= bp + 3) k = (p >> 3) - bp;
    if (ty == 2) begin
      dr = (cl == 0) ? 0 : 1;
      dc = (cl == 1) ? 0 : (cl == 3) ? -1 : 1;
      ra = r - dr; ca = c - dc; rb = r + dr; cb = c + dc;
      if (ra >= 0 && rb < s && ca >= 0 && ca < s && cb >= 0 && cb < s) begin
        sg = (int'(p > img[ra][ca]) - int'(p < img[ra][ca])) + (int'(p > img[rb][cb]) - int'(p < img[rb][cb]));
        k = sg == -2 ? 0 : sg == -1 ? 1 : sg == 1 ? 2 : sg == 2 ? 3 : -1;
      end
    end
    if (k < 0) return p;
    v = int'((off >> (4 * (3 - k))) & 16'hF);
    if (v > 7) v -= 16;
    p += v;
    return p < 0 ? 0 : p > 255 ? 255 : p;
  endfunction

  task automatic fill(input int mode, input int s);
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++)
        img[r][c] = mode == 0 ? int'($urandom_range(0, 255)) :
                    mode == 1 ? ($urandom_range(0, 1) != 0 ? int'($urandom_range(0, 3)) : int'($urandom_range(252, 255))) :
                    mode == 2 ? (r * s + c) % 256 : 100 + int'($urandom_range(0, 3));
  endtask

  task automatic send(input int ty, bp, cl, input logic [15:0] off, input int lx, ly, sz, npix);
    int s, i, g;
    bit pend, eb;
    exp_t e;
    s = 16 << sz; i = 0; g = 0; pend = 0; eb = 0;
    cur_s = s;
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++) begin
        e.d = 8'(ref_pix(r, c, s, ty, bp, cl, off));
        e.a = 14'((ly * s + r) * 128 + lx * s + c);
        exp_q.push_back(e);
      end
    while (i < npix && g < 200000) begin
      @(negedge clk);
      g++;
      if (pend) begin chk("busy_after_pix", busy, eb); pend = 0; end
      if (busy) begin
        in_en = $urandom_range(0, 1) != 0;
        din = 8'($urandom);
      end else if ($urandom_range(0, 7) == 0) in_en = 1'b0;
      else begin
        in_en = 1'b1;
        din = 8'(img[i / s][i % s]);
        if (i == 0) begin
          ipf_type = 2'(ty); ipf_band_pos = 5'(bp); ipf_wo_class = 2'(cl); ipf_offset = off;
          lcu_x = 3'(lx); lcu_y = 3'(ly); lcu_size = 2'(sz);
        end else begin
          ipf_type = 2'($urandom); ipf_band_pos = 5'($urandom); ipf_wo_class = 2'($urandom);
          ipf_offset = 16'($urandom); lcu_x = 3'($urandom); lcu_y = 3'($urandom); lcu_size = 2'($urandom);
        end
        eb = (i % s == s - 1) && (i / s >= 1);
        pend = 1;
        i++;
      end
    end
    @(negedge clk);
    if (pend) chk("busy_after_pix", busy, eb);
    in_en = 1'b0;
    if (i < npix) chk("send_timeout", i, npix);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 40000) begin @(negedge clk); #1; g++; end
    chk("drain_left", exp_q.size(), 0);
    chk("finish_early", finish, 0);
  endtask

  always @(negedge clk) begin
    if (out_en) begin
      n_out++;
      chk("out_in_busy_window", busy | busy_prev, 1);
      if (cap_first) begin first_addr = dout_addr; cap_first = 0; end
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: dout=%0d addr=%0d with empty queue at %0t", dout, dout_addr, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dout", dout, e.d);
        chk("dout_addr", dout_addr, e.a);
      end
    end
    if (!reset) run = 0;
    else if (out_en) run++;
    else if (run != 0) begin
      chk("burst_len", run, run > cur_s ? 2 * cur_s : cur_s);
      run = 0;
    end
    busy_prev = busy;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_out_en", out_en, 0); chk("rst_dout", dout, 0);
    chk("rst_addr", dout_addr, 0); chk("rst_finish", finish, 0);
    reset = 1'b1;
    // reset in the middle of an output burst discards the partial LCU
    fill(0, 16);
    send(0, 0, 0, 16'h0, 1, 1, 0, 48);
    g = 0;
    while (!out_en && g < 100) begin @(negedge clk); g++; end
    chk("reset_wait_out", out_en, 1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_out_en", out_en, 0); chk("mid_rst_dout", dout, 0);
    chk("mid_rst_addr", dout_addr, 0); chk("mid_rst_finish", finish, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = n_out;
    fill(0, 16);
    send(0, 0, 0, 16'h0, 1, 1, 0, 256);
    drain();
    chk("post_reset_count", n_out - base, 256);
    // OFF, ramp pixels, LCU (2,3)
    fill(2, 16);
    cap_first = 1;
    send(0, 0, 0, 16'h0, 2, 3, 0, 256);
    drain();
    chk("first_addr", first_addr, 6176);
    // PO band_pos=4, offsets +3,-2,+7,-8
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int lst [5] = '{32, 41, 48, 56, 64};
        img[r][c] = lst[(r * 16 + c) % 5];
      end
    send(1, 4, 0, 16'h3E78, 0, 2, 0, 256);
    drain();
    // PO band_pos=31, o0=+7 saturates at the top
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int lst [5] = '{250, 248, 255, 247, 0};
        img[r][c] = lst[(r * 16 + c) % 5];
      end
    send(1, 31, 0, 16'h7000, 5, 0, 0, 256);
    drain();
    // WO diagonal classes with planted neighbourhoods
    fill(3, 16);
    img[5][5] = 10; img[4][4] = 20; img[6][6] = 30;
    img[8][8] = 40; img[7][7] = 20; img[9][9] = 40;
    send(2, 0, 2, 16'h5A3C, 3, 4, 0, 256);
    drain();
    fill(3, 16);
    img[5][5] = 10; img[4][6] = 20; img[6][4] = 30;
    send(2, 0, 3, 16'h7F18, 6, 7, 0, 256);
    drain();
    // randomized LCUs of mixed type and size
    for (int n = 0; n < 8; n++) begin
      int sz, lim;
      sz = $urandom_range(0, 1);
      lim = (8 >> sz) - 2;
      fill($urandom_range(0, 3) == 2 ? 0 : $urandom_range(0, 3), 16 << sz);
      send($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3), 16'($urandom),
           $urandom_range(0, lim), $urandom_range(0, lim + 1), sz, (16 << sz) * (16 << sz));
      drain();
    end
    // full frame of four 64x64 LCUs
    base = n_out;
    fill(1, 64); send(2, 0, $urandom_range(0, 3), 16'($urandom), 0, 0, 2, 4096);
    fill(0, 64); send(1, $urandom_range(0, 28), 0, 16'($urandom), 1, 0, 2, 4096);
    fill(0, 64); send(0, 0, 0, 16'($urandom), 0, 1, 2, 4096);
    fill(3, 64); send(2, 0, $urandom_range(0, 3), 16'($urandom), 1, 1, 2, 4096);
    drain();
    chk("frame_count", n_out - base, 16384);
    @(negedge clk);
    chk("finish_rise", finish, 1); chk("finish_busy", busy, 0); chk("finish_out_en", out_en, 0);
    base = n_out;
    in_en = 1'b1;
    repeat (20) @(negedge clk);
    in_en = 1'b0;
    chk("finish_sticky", finish, 1);
    chk("finish_no_out", n_out - base, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ipf_gen.md
# ipf_gen

Parametrised in-loop pixel filter for one colour plane. It is the next generation of the team's LCU post-filter and accepts raster-ordered LCU pixels from the reconstruction stage. Each pixel is filtered with OFF, band offset (PO) or edge offset (WO, four directions) and written out with its absolute frame address. PIX_W, frame size and maximum LCU size are generic; the diagonal WO classes and signed-offset clipping at any pixel width are new relative to the previous generation.

## Interface
- PIX_W, 8: pixel width in bits (≥5).
- OFF_W, 4: width of each signed two's-complement offset.
- IMG_W, 128: square frame side in pixels, power of two; AW = 2·log2(IMG_W).
- LCU_MAX, 64: largest supported LCU side, power of two, 16 ≤ LCU_MAX ≤ IMG_W; sizes line buffers.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_en  in  1  din valid; honoured only while busy=0.
- din  in  PIX_W  input pixel, LCU raster order.
- ipf_type  in  2  0 OFF, 1 PO, 2 WO, 3 treated as OFF.
- ipf_band_pos  in  5  first of four PO bands.
- ipf_wo_class  in  2  0 horizontal, 1 vertical, 2 diagonal 135° (UL/DR), 3 diagonal 45° (UR/DL).
- ipf_offset  in  4·OFF_W  offsets o0..o3, o0 in MSBs.
- lcu_x, lcu_y  in  log2(IMG_W/16) each  LCU column/row index.
- lcu_size  in  2  LCU side S = 16<<lcu_size; S ≤ LCU_MAX required, larger values unsupported.
- busy  out  1  block is emitting; upstream must hold in_en low.
- out_en  out  1  dout/dout_addr valid this cycle.
- dout  out  PIX_W  filtered pixel.
- dout_addr  out  AW  (lcu_y·S + row)·IMG_W + lcu_x·S + col.
- finish  out  1  whole frame emitted; sticky.

## Operation
- Sideband (type, band_pos, wo_class, offset, lcu_*) is captured on the first accepted pixel of each LCU. It is held for the whole LCU, and mid-LCU changes are ignored.
- Storage is a 3-row circular line buffer of LCU_MAX pixels each. No full-LCU storage.
- FSM states: READ, OUT, FINISH.
  - READ: accept pixels.
  - Row 0 complete: stay in READ.
  - Row r+1 complete (r+1 ≤ S-1): go to OUT and emit row r.
  - After last row received: emit row S-2, then row S-1, back-to-back in one OUT visit.
  - OUT end: if lcu_x = lcu_y = IMG_W/S−1, go to FINISH; else go to READ and reset row/col pointers.
  - FINISH: absorbing until reset.
- PO:
  - band = pix >> (PIX_W−5).
  - If band_pos ≤ band ≤ band_pos+3 (no wrap, so bands >31 never match): k = band−band_pos, dout = clip(pix + o_k).
  - Otherwise dout = pix.
- WO: neighbours a,b by class. Pixel unchanged if either neighbour lies outside the LCU (LCU border rows/cols per class). Categories:
  - c<a && c<b → +o0.
  - (c<a && c==b) or (c==a && c<b) → +o1.
  - (c>a && c==b) or (c==a && c>b) → +o2.
  - c>a && c>b → +o3.
  - All other cases: unchanged.
- Arithmetic: sign-extend o_k to PIX_W+1, add in PIX_W+1 bits, clip to [0, 2^PIX_W−1].
- in_en while busy=1: sample dropped, no state change.

## Timing
- Reset (async assert, sync release): busy=0, out_en=0, dout=0, dout_addr=0, finish=0. FSM enters READ with pointers at 0. Buffer contents are not cleared and are never output before being rewritten.
- Reset mid-LCU or mid-OUT: outputs go to reset values immediately, and the partial LCU is discarded.
- Input throughput is one pixel per accepted in_en cycle. Gaps are allowed.
- Edge E0 samples the last pixel of row r+1, and busy=1 from E0.
- Outputs for (r,0..S−1) are registered at edges E1..ES, with out_en=1 over exactly S consecutive cycles.
- busy falls at ES, so a new pixel can be accepted at ES+1. For the last row, 2S outputs are emitted contiguously.
- finish rises the edge after the last out_en of the final LCU and stays high. busy=0 and out_en=0 in FINISH.
- out_en is never high while busy=0, except none: out_en ⊆ busy-window shifted by one cycle.

## Test plan
- Reset: pull reset low in the middle of an OUT burst, then release and send a fresh 16×16 OFF LCU. Outputs are 0 asynchronously; afterwards exactly 256 outputs with correct values and no stale pixels.
- OFF, lcu_size=0, lcu (2,3), din=k mod 256: dout=din, and the first dout_addr is 48·128+32=6176. busy rises after pixel 31 is sampled (2nd row complete), and out_en lasts 16 cycles per burst.
- PO, band_pos=4, ipf_offset=16'h3E78 (o=+3,−2,+7,−8):
  - 32→35, 41→39, 48→55, 56→48, 64→64 (band 8).
  - With band_pos=31 and o0=+7: 250→255 (clip).
- WO class 2: centre 10, UL 20, DR 30 → 10+o0. Centre 40 with UL 20 and DR 40 → +o2. Row 0, col 0, row S−1 and col S−1 are unchanged. Class 3 uses UR/DL.
- Frame, lcu_size=2: LCUs (0,0),(1,0),(0,1),(1,1) give 16384 outputs. The last dout_addr is 16383, finish=1 one cycle after it and stays high.
- Protocol: hold in_en=1 with changing din throughout busy. Dropped samples do not appear, and row contents match only samples accepted while busy=0.
